dmar_2d_sched: RTL
==================

// Module: dmar_2d_sched
// PURPOSE
//  2-channel 2D read-DMA scheduler in front of the 1D AXI read engine (dma_r_req0/1 ports).
//  Per channel: takes a 2D descriptor (start addr, line length, line count, stride) and issues
//  one 1D read request per line. Counts per-line completions from the read-data return path
//  and reports busy/done/aborted to the register block.
// PARAMETERS
//  OUTSTD_MAX  2   max issued-but-not-completed 1D lines per channel (1..7)
// PORTS  (X = 0,1; one set per channel)
//  clk             in   1   system clock
//  rst             in   1   async reset, active-high
//  cfg_dma_halt    in   1   1: mask all new 1D requests, state held
//  chX_start       in   1   pulse: accept descriptor (IDLE only)
//  chX_abort       in   1   pulse: stop issuing, drain, finish
//  chX_saddr       in   32  byte start addr of line 0
//  chX_line_len    in   16  byte length per line, cnt from 0
//  chX_line_num    in   12  number of lines, cnt from 0
//  chX_stride      in   32  byte addr increment between lines
//  chX_busy        out  1   descriptor in progress
//  chX_done        out  1   1-cycle pulse at completion
//  chX_aborted     out  1   sticky: last descriptor ended by abort; cleared on next accepted start
//  dma_r_reqX      out  1   1D request to read engine
//  dma_r_ackX      in   1   request accepted
//  dma_r_addrX     out  32  1D byte addr
//  dma_r_lenX      out  16  1D byte length, cnt from 0
//  dma_dvldX       in   1   read data valid (monitor only)
//  dma_dackX       in   1   read data accepted by consumer (monitor only)
//  dma_rd_lastX    in   1   last beat of a 1D request (monitor only)
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0, aborted 0.
//  FSM per channel: IDLE -> REQ -> (WAIT) -> DRAIN -> DONE -> IDLE.
//  IDLE: start latches saddr/len/line_num/stride; next cycle REQ, busy=1. Start in other states ignored.
//  REQ: dma_r_req = !cfg_dma_halt; addr = line_addr, len = line_len. Addr/len stable until ack.
//    On ack: line_addr += stride (mod 2^32, no 4KB check here; engine splits), issued++, outstd++.
//    Last line acked -> DRAIN; else outstd reaches OUTSTD_MAX -> WAIT; else stay REQ (new addr next cycle).
//  WAIT: req=0; completion with outstd < OUTSTD_MAX after update -> REQ.
//  Completion cpl = dma_dvldX & dma_dackX & dma_rd_lastX; outstd-- (saturate at 0, stray cpl ignored).
//  Ack and cpl in same cycle: outstd unchanged.
//  DRAIN: req=0; when outstd (after this cycle's update) == 0 -> DONE.
//  DONE: done=1 one cycle, busy=0 on the same cycle, -> IDLE.
//  Abort in REQ/WAIT: -> DRAIN, aborted=1; an ack in the same cycle still counts as outstanding.
//    Abort in IDLE/DRAIN/DONE ignored.
//  Halt: freezes issue only; completions still counted; resuming continues the same line.
//  Latency: start -> first dma_r_req = 1 cycle; last cpl -> done = 1 cycle.
//  rst mid-operation: immediate return to IDLE, no done pulse; outstanding engine data not tracked.
// CONFIGURATION
//  `DMAR_SCHED_PERF_EN defined: adds output chX_busy_cyc[31:0] counting cycles with busy=1,
//    cleared on accepted start, wraps at 2^32, held after done.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package dmar_pkg: FSM state encoding (IDLE/REQ/WAIT/DRAIN/DONE), ADDR_W=32, LEN_W=16,
//    LNUM_W=12, descriptor struct {saddr, line_len, line_num, stride}.
//  Sub-module dmar_2d_ch: one channel FSM + counters; top instantiates it twice, no shared state.
// TESTING
//  1) ch0 saddr=0x1000, len=63, line_num=3, stride=0x100, ack 1 cycle after req, cpl 4 cycles later
//     -> 4 reqs addr 0x1000/0x1100/0x1200/0x1300 len=63; done pulse 1 cycle after 4th cpl.
//  2) OUTSTD_MAX=2, no cpl returned -> exactly 2 acks then req=0 (WAIT); one cpl -> req reasserts next cycle.
//  3) Abort after 2nd ack of line_num=7 -> no 3rd req; done after 2 cpls; aborted=1 until next start.
//  4) saddr=0xFFFF_FF00, stride=0x100, line_num=1 -> 2nd addr 0x0000_0000 (wrap); cfg_dma_halt=1
//     for 5 cycles mid-REQ -> req=0 throughout, same addr issued on release.
//  5) ch0 and ch1 started same cycle, line_num=2 each -> both complete independently, ack per channel;
//     ack+cpl same cycle keeps outstd; rst asserted mid-DRAIN -> busy=0, req=0 next edge, no done.

Source files
------------

// File: rtl/dmar_pkg.sv
// Shared types for the 2-channel 2D read-DMA scheduler.
// Holds the channel FSM encoding, the address/length/line-count widths and
// the 2D descriptor layout presented by the register block.
package dmar_pkg;

   localparam int ADDR_W = 32;
   localparam int LEN_W  = 16;
   localparam int LNUM_W = 12;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } ch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] saddr;
      logic [LEN_W-1:0]  line_len;
      logic [LNUM_W-1:0] line_num;
      logic [ADDR_W-1:0] stride;
   } desc_t;

   // Outstanding-line update: an issue and a completion in the same cycle
   // cancel; a completion with nothing outstanding is a stray and is dropped.
   function automatic logic [2:0] outstd_upd(input logic [2:0] cur,
                                             input logic       issue,
                                             input logic       cpl);
      logic [2:0] res;
      res = cur;
      if (issue && !cpl)
         res = cur + 3'd1;
      else if (!issue && cpl && (cur != 3'd0))
         res = cur - 3'd1;
      return res;
   endfunction

endpackage

// File: rtl/dmar_2d_ch.sv
// One 2D read-DMA channel: walks a 2D descriptor line by line, issuing one
// 1D request per line, and limits issued-but-uncompleted lines to OUTSTD_MAX.
// Optional feature macro: DMAR_SCHED_PERF_EN adds a busy-cycle counter.
module dmar_2d_ch
   import dmar_pkg::*;
#(
   parameter int OUTSTD_MAX = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt,
   input  logic              start,
   input  logic              abort,
   input  desc_t             desc,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic              req,
   input  logic              ack,
   output logic [ADDR_W-1:0] addr,
   output logic [LEN_W-1:0]  len,
   input  logic              dvld,
   input  logic              dack,
   input  logic              rd_last
`ifdef DMAR_SCHED_PERF_EN
   ,
   output logic [31:0]       busy_cyc
`endif
);

   localparam logic [2:0] OMAX = 3'(OUTSTD_MAX);

   ch_state_e         state_q, state_d;
   logic [ADDR_W-1:0] line_addr_q;
   logic [LEN_W-1:0]  line_len_q;
   logic [LNUM_W-1:0] line_num_q;
   logic [ADDR_W-1:0] stride_q;
   logic [LNUM_W-1:0] issued_q;
   logic [2:0]        outstd_q, outstd_d;
   logic              aborted_q;
   logic              issue, cpl, last_line, start_ok;

   assign req       = (state_q == ST_REQ) && !halt;
   assign issue     = req && ack;
   assign cpl       = dvld && dack && rd_last;
   assign last_line = (issued_q == line_num_q);
   assign start_ok  = (state_q == ST_IDLE) && start;
   assign outstd_d  = outstd_upd(outstd_q, issue, cpl);

   assign busy    = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_DRAIN);
   assign done    = (state_q == ST_DONE);
   assign aborted = aborted_q;
   assign addr    = line_addr_q;
   assign len     = line_len_q;

   // Next-state selection for the channel walk
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_REQ;
         ST_REQ: begin
            if (abort || (issue && last_line)) state_d = ST_DRAIN;
            else if (outstd_d >= OMAX)         state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (abort)                state_d = ST_DRAIN;
            else if (outstd_d < OMAX) state_d = ST_REQ;
         end
         ST_DRAIN: if (outstd_d == 3'd0) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Descriptor latch, line walk and outstanding/abort bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_addr_q <= '0;
         line_len_q  <= '0;
         line_num_q  <= '0;
         stride_q    <= '0;
         issued_q    <= '0;
         outstd_q    <= '0;
         aborted_q   <= 1'b0;
      end else begin
         outstd_q <= outstd_d;
         if (start_ok) begin
            line_addr_q <= desc.saddr;
            line_len_q  <= desc.line_len;
            line_num_q  <= desc.line_num;
            stride_q    <= desc.stride;
            issued_q    <= '0;
            outstd_q    <= '0;
            aborted_q   <= 1'b0;
         end else begin
            if (issue) begin
               line_addr_q <= line_addr_q + stride_q;
               issued_q    <= issued_q + 1'b1;
            end
            if (abort && ((state_q == ST_REQ) || (state_q == ST_WAIT)))
               aborted_q <= 1'b1;
         end
      end
   end

`ifdef DMAR_SCHED_PERF_EN
   logic [31:0] busy_cyc_q;
   assign busy_cyc = busy_cyc_q;

   // Busy-cycle counter: cleared on accepted start, held once idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           busy_cyc_q <= '0;
      else if (start_ok) busy_cyc_q <= '0;
      else if (busy)     busy_cyc_q <= busy_cyc_q + 32'd1;
   end
`endif

endmodule

// File: rtl/dmar_2d_sched.sv
// Two independent 2D read-DMA channels in front of the 1D AXI read engine.
// Each channel is a separate dmar_2d_ch instance; nothing is shared but
// the global halt.
// Optional feature macro: DMAR_SCHED_PERF_EN adds chX_busy_cyc outputs.
module dmar_2d_sched
   import dmar_pkg::*;
#(
   parameter int OUTSTD_MAX = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_dma_halt,
   input  logic              ch0_start,
   input  logic              ch0_abort,
   input  logic [ADDR_W-1:0] ch0_saddr,
   input  logic [LEN_W-1:0]  ch0_line_len,
   input  logic [LNUM_W-1:0] ch0_line_num,
   input  logic [ADDR_W-1:0] ch0_stride,
   output logic              ch0_busy,
   output logic              ch0_done,
   output logic              ch0_aborted,
   input  logic              ch1_start,
   input  logic              ch1_abort,
   input  logic [ADDR_W-1:0] ch1_saddr,
   input  logic [LEN_W-1:0]  ch1_line_len,
   input  logic [LNUM_W-1:0] ch1_line_num,
   input  logic [ADDR_W-1:0] ch1_stride,
   output logic              ch1_busy,
   output logic              ch1_done,
   output logic              ch1_aborted,
   output logic              dma_r_req0,
   input  logic              dma_r_ack0,
   output logic [ADDR_W-1:0] dma_r_addr0,
   output logic [LEN_W-1:0]  dma_r_len0,
   input  logic              dma_dvld0,
   input  logic              dma_dack0,
   input  logic              dma_rd_last0,
   output logic              dma_r_req1,
   input  logic              dma_r_ack1,
   output logic [ADDR_W-1:0] dma_r_addr1,
   output logic [LEN_W-1:0]  dma_r_len1,
   input  logic              dma_dvld1,
   input  logic              dma_dack1,
   input  logic              dma_rd_last1
`ifdef DMAR_SCHED_PERF_EN
   ,
   output logic [31:0]       ch0_busy_cyc,
   output logic [31:0]       ch1_busy_cyc
`endif
);

   desc_t desc0, desc1;

   assign desc0 = '{saddr: ch0_saddr, line_len: ch0_line_len,
                    line_num: ch0_line_num, stride: ch0_stride};
   assign desc1 = '{saddr: ch1_saddr, line_len: ch1_line_len,
                    line_num: ch1_line_num, stride: ch1_stride};

   dmar_2d_ch #(.OUTSTD_MAX(OUTSTD_MAX)) u_ch0 (
      .clk     (clk),
      .rst     (rst),
      .halt    (cfg_dma_halt),
      .start   (ch0_start),
      .abort   (ch0_abort),
      .desc    (desc0),
      .busy    (ch0_busy),
      .done    (ch0_done),
      .aborted (ch0_aborted),
      .req     (dma_r_req0),
      .ack     (dma_r_ack0),
      .addr    (dma_r_addr0),
      .len     (dma_r_len0),
      .dvld    (dma_dvld0),
      .dack    (dma_dack0),
      .rd_last (dma_rd_last0)
`ifdef DMAR_SCHED_PERF_EN
      ,
      .busy_cyc(ch0_busy_cyc)
`endif
   );

   dmar_2d_ch #(.OUTSTD_MAX(OUTSTD_MAX)) u_ch1 (
      .clk     (clk),
      .rst     (rst),
      .halt    (cfg_dma_halt),
      .start   (ch1_start),
      .abort   (ch1_abort),
      .desc    (desc1),
      .busy    (ch1_busy),
      .done    (ch1_done),
      .aborted (ch1_aborted),
      .req     (dma_r_req1),
      .ack     (dma_r_ack1),
      .addr    (dma_r_addr1),
      .len     (dma_r_len1),
      .dvld    (dma_dvld1),
      .dack    (dma_dack1),
      .rd_last (dma_rd_last1)
`ifdef DMAR_SCHED_PERF_EN
      ,
      .busy_cyc(ch1_busy_cyc)
`endif
   );

endmodule
